// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_mem_pkg
//  Description : Shared memory-subsystem definitions. Holds the access state
//                encoding and the default CPU byte address that maps to SRAM
//                location 0. Intended to be reused by the SRAM controller and
//                the future cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

  // Access sequencer states: IDLE waits for a request, LOW/HIGH perform the
  // two 16-bit half accesses, DONE is the single completion cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // CPU byte address that lands on SRAM half-word 0.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage : arm_mem_pkg
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : Bridges the CPU memory stage to a 16-bit asynchronous SRAM.
//                Each 32-bit load/store becomes two half-word accesses, each
//                lasting WAIT_CYCLES clocks. ready is low while an access is
//                in flight so the top level can freeze the pipeline.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    BASE_ADDR   : CPU byte address mapped to SRAM word 0
//    WAIT_CYCLES : clocks per half access (2..15)
//    SRAM_AW     : SRAM address width in 16-bit locations
//  Ports
//    clk         in   system clock, rising edge
//    rst         in   asynchronous reset, active low
//    rd_en       in   load request, held until ready
//    wr_en       in   store request, held until ready (wins over rd_en)
//    address     in   CPU byte address
//    write_data  in   store data
//    read_data   out  load result, valid in the ready cycle ending a read
//    ready       out  1 = idle or completing, 0 = freeze pipeline
//    sram_addr   out  SRAM half-word address (registered)
//    sram_dq     io   SRAM data bus, high-Z unless writing
//    sram_we_n   out  SRAM write strobe, active low (registered)
// ============================================================================
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [15:0]        sram_dq,
  output logic               sram_we_n
);

  localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

  mem_state_e          r_state;
  mem_state_e          w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                w_load;

  logic                r_is_wr;
  logic [SRAM_AW-2:0]  r_off;
  logic [31:0]         r_wdata;
  logic [15:0]         r_rd_lo;
  logic [31:0]         r_read_data;

  logic [SRAM_AW-1:0]  r_sram_addr;
  logic                r_we_n;
  logic                r_oe;
  logic [15:0]         r_dq_out;

  logic                w_req;
  logic                w_last;
  logic [SRAM_AW-2:0]  w_off_in;
  logic                w_op_wr;
  logic [SRAM_AW-2:0]  w_off;
  logic [31:0]         w_wdata;
  logic                w_phase_nxt;
  logic                w_high_nxt;
  logic [SRAM_AW-1:0]  w_addr_nxt;
  logic                w_oe_nxt;
  logic [15:0]         w_dq_nxt;
  logic                w_we_n_nxt;

  assign w_req  = rd_en | wr_en;
  assign w_last = (r_cnt == c_LAST);

  // Unsigned word offset; addresses below the base simply wrap.
  assign w_off_in = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

  // ---------------------------------------------------------------------------
  // Next-state / combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    ready       = 1'b0;
    case (r_state)
      IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_load      = 1'b1;
          w_state_nxt = LOW;
          w_cnt_nxt   = 4'd0;
        end
      end
      LOW: begin
        if (w_last) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      HIGH: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      DONE: begin
        ready       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    // Pipeline is never frozen while the controller is held in reset.
    if (!rst) begin
      ready = 1'b1;
    end
  end

  // The SRAM-facing pins are registered, so their next values are derived
  // from the next state/count. In the request cycle the operands come
  // straight from the inputs because the latches have not loaded yet.
  assign w_op_wr     = w_load ? wr_en      : r_is_wr;
  assign w_off       = w_load ? w_off_in   : r_off;
  assign w_wdata     = w_load ? write_data : r_wdata;
  assign w_phase_nxt = (w_state_nxt == LOW) || (w_state_nxt == HIGH);
  assign w_high_nxt  = (w_state_nxt == HIGH);
  assign w_addr_nxt  = w_phase_nxt ? {w_off, w_high_nxt} : r_sram_addr;
  assign w_oe_nxt    = w_phase_nxt & w_op_wr;
  assign w_dq_nxt    = w_high_nxt ? w_wdata[31:16] : w_wdata[15:0];
  // Strobe released on the last phase cycle so address/data are held past
  // the rising edge of we_n.
  assign w_we_n_nxt  = ~(w_oe_nxt && (w_cnt_nxt != c_LAST));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_off       <= '0;
      r_wdata     <= 32'd0;
      r_rd_lo     <= 16'd0;
      r_read_data <= 32'd0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_dq_out    <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sram_addr <= w_addr_nxt;
      r_we_n      <= w_we_n_nxt;
      r_oe        <= w_oe_nxt;
      r_dq_out    <= w_dq_nxt;
      if (w_load) begin
        r_is_wr <= wr_en;
        r_off   <= w_off_in;
        r_wdata <= write_data;
      end
      // Read data is sampled at the end of each half so the SRAM has had the
      // full wait time to settle.
      if ((r_state == LOW) && w_last && !r_is_wr) begin
        r_rd_lo <= sram_dq;
      end
      if ((r_state == HIGH) && w_last && !r_is_wr) begin
        r_read_data <= {sram_dq, r_rd_lo};
      end
    end
  end

  assign read_data = r_read_data;
  assign sram_addr = r_sram_addr;
  assign sram_we_n = r_we_n;
  assign sram_dq   = r_oe ? r_dq_out : 16'hzzzz;

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_controller
//  Description : Directed self-checking bench for sram_controller. Two
//                instances share clock and reset: u_dut2 (WAIT_CYCLES=2) and
//                u_dut3 (WAIT_CYCLES=3), each attached to a small SRAM model
//                that latches on the rising edge of we_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  logic clk;
  logic rst;

  // WAIT=2 instance
  logic        s2_rd, s2_wr;
  logic [31:0] s2_a, s2_wd, s2_read_data;
  logic        s2_ready, s2_we_n;
  logic [17:0] s2_addr;
  wire  [15:0] s2_dq;

  // WAIT=3 instance
  logic        s3_rd, s3_wr;
  logic [31:0] s3_a, s3_wd, s3_read_data;
  logic        s3_ready, s3_we_n;
  logic [17:0] s3_addr;
  wire  [15:0] s3_dq;

  // SRAM models
  logic [15:0] mem2 [0:63];
  logic [15:0] mem3 [0:63];
  logic        m2_en, m3_en, arm;

  int n_cmp, n_err;

  // run2 results
  int          o_low, we_lo, we_hi;
  logic [17:0] a_lo, a_hi;
  logic [15:0] dq_lo, dq_hi;
  logic [31:0] rd_obs;

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(18)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (s2_rd),
    .wr_en      (s2_wr),
    .address    (s2_a),
    .write_data (s2_wd),
    .read_data  (s2_read_data),
    .ready      (s2_ready),
    .sram_addr  (s2_addr),
    .sram_dq    (s2_dq),
    .sram_we_n  (s2_we_n)
  );

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3), .SRAM_AW(18)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (s3_rd),
    .wr_en      (s3_wr),
    .address    (s3_a),
    .write_data (s3_wd),
    .read_data  (s3_read_data),
    .ready      (s3_ready),
    .sram_addr  (s3_addr),
    .sram_dq    (s3_dq),
    .sram_we_n  (s3_we_n)
  );

  assign s2_dq = m2_en ? mem2[s2_addr[5:0]] : 16'hzzzz;
  assign s3_dq = m3_en ? mem3[s3_addr[5:0]] : 16'hzzzz;

  always @(posedge s2_we_n) if (arm) mem2[s2_addr[5:0]] = s2_dq;
  always @(posedge s3_we_n) if (arm) mem3[s3_addr[5:0]] = s3_dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Follows an access on u_dut2 from the request cycle to DONE, collecting
  // per-half observations. Returns at the negedge of the DONE cycle.
  task automatic run2();
    bit done;
    done  = 1'b0;
    o_low = 0; we_lo = 0; we_hi = 0;
    a_lo  = '0; a_hi = '0; dq_lo = '0; dq_hi = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (s2_ready) begin
        done = 1'b1;
      end else begin
        o_low++;
        if (s2_addr[0]) begin
          a_hi  = s2_addr;
          dq_hi = s2_dq;
          if (!s2_we_n) we_hi++;
        end else begin
          a_lo  = s2_addr;
          dq_lo = s2_dq;
          if (!s2_we_n) we_lo++;
        end
      end
    end
    check_eq("done2", {31'd0, done}, 32'd1);
    rd_obs = s2_read_data;
    s2_rd  = 1'b0;
    s2_wr  = 1'b0;
    m2_en  = 1'b0;
  endtask

  task automatic acc2(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    s2_wr = w;
    s2_rd = r;
    s2_a  = a;
    s2_wd = d;
    m2_en = r && !w;
    #1;
    check_eq("req_cycle_ready", {31'd0, s2_ready}, 32'd0);
    run2();
  endtask

  initial begin
    int   low, gap;
    bit   done;
    logic idle_ready;
    n_cmp = 0; n_err = 0;
    arm = 1'b0; m2_en = 1'b0; m3_en = 1'b0;
    s2_rd = 0; s2_wr = 0; s2_a = 0; s2_wd = 0;
    s3_rd = 0; s3_wr = 0; s3_a = 0; s3_wd = 0;
    for (int i = 0; i < 64; i++) begin
      mem2[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
    mem3[0] = 16'h1111; mem3[1] = 16'h2222;
    mem3[2] = 16'h3333; mem3[3] = 16'h4444;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready",     {31'd0, s2_ready},  32'd1);
    check_eq("rst_we_n",      {31'd0, s2_we_n},   32'd1);
    check_eq("rst_read_data", s2_read_data,       32'd0);
    check_eq("rst_sram_addr", {14'd0, s2_addr},   32'd0);
    rst = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", {31'd0, s2_ready}, 32'd1);

    // Write 0x12345678 to 1024
    acc2(1'b1, 1'b0, 32'd1024, 32'h1234_5678);
    check_eq("w1_low_cycles", o_low, 32'd4);
    check_eq("w1_we_lo",      we_lo, 32'd1);
    check_eq("w1_we_hi",      we_hi, 32'd1);
    check_eq("w1_mem0",       {16'd0, mem2[0]}, 32'h5678);
    check_eq("w1_mem1",       {16'd0, mem2[1]}, 32'h1234);

    // Read it back
    acc2(1'b0, 1'b1, 32'd1024, 32'd0);
    check_eq("r1_low_cycles", o_low,  32'd4);
    check_eq("r1_data",       rd_obs, 32'h1234_5678);
    check_eq("r1_no_strobe",  we_lo + we_hi, 32'd0);

    // Write 0xDEADBEEF to 1028
    acc2(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
    check_eq("w2_addr_lo", {14'd0, a_lo},  32'd2);
    check_eq("w2_addr_hi", {14'd0, a_hi},  32'd3);
    check_eq("w2_dq_lo",   {16'd0, dq_lo}, 32'hBEEF);
    check_eq("w2_dq_hi",   {16'd0, dq_hi}, 32'hDEAD);
    check_eq("w2_mem2",    {16'd0, mem2[2]}, 32'hBEEF);
    check_eq("w2_mem3",    {16'd0, mem2[3]}, 32'hDEAD);
    check_eq("w2_mem0_kept", {16'd0, mem2[0]}, 32'h5678);
    check_eq("w2_mem1_kept", {16'd0, mem2[1]}, 32'h1234);

    // Read and write together: write wins, read_data untouched
    acc2(1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A);
    check_eq("both_mem4",  {16'd0, mem2[4]}, 32'h5A5A);
    check_eq("both_mem5",  {16'd0, mem2[5]}, 32'hA5A5);
    check_eq("both_rdata", rd_obs, 32'h1234_5678);

    // Address below base wraps: offset 0x1FFFF
    acc2(1'b1, 1'b0, 32'd1020, 32'h0BAD_C0DE);
    check_eq("wrap_addr_lo", {14'd0, a_lo}, 32'h3FFFE);
    check_eq("wrap_addr_hi", {14'd0, a_hi}, 32'h3FFFF);
    check_eq("wrap_mem62",   {16'd0, mem2[62]}, 32'hC0DE);
    check_eq("wrap_mem63",   {16'd0, mem2[63]}, 32'h0BAD);

    // WAIT=3: back-to-back reads at 1024 and 1028
    @(negedge clk);
    s3_rd = 1'b1; s3_a = 32'd1024; m3_en = 1'b1;
    #1;
    check_eq("w3_req_ready", {31'd0, s3_ready}, 32'd0);
    low = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); @(negedge clk);
      if (s3_ready) done = 1'b1; else low++;
    end
    check_eq("w3_r1_done",  {31'd0, done}, 32'd1);
    check_eq("w3_r1_low",   low, 32'd6);
    check_eq("w3_r1_data",  s3_read_data, 32'h2222_1111);
    s3_a = 32'd1028;
    gap = 0; done = 1'b0; idle_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); @(negedge clk);
      gap++;
      if (gap == 1) idle_ready = s3_ready;
      if (s3_addr == 18'd2) done = 1'b1;
    end
    check_eq("w3_gap_to_low",  gap, 32'd2);
    check_eq("w3_idle_ready",  {31'd0, idle_ready}, 32'd0);
    low = gap; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); @(negedge clk);
      if (s3_ready) done = 1'b1; else low++;
    end
    check_eq("w3_r2_done", {31'd0, done}, 32'd1);
    check_eq("w3_r2_low",  low, 32'd7);
    check_eq("w3_r2_data", s3_read_data, 32'h4444_3333);
    s3_rd = 1'b0; m3_en = 1'b0;

    // Reset during the first LOW cycle of a write
    @(negedge clk);
    s2_wr = 1'b1; s2_a = 32'd1040; s2_wd = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    check_eq("abort_we_low", {31'd0, s2_we_n}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_we_high", {31'd0, s2_we_n},  32'd1);
    check_eq("abort_ready",   {31'd0, s2_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("restart_idle_ready", {31'd0, s2_ready}, 32'd0);
    check_eq("restart_we_n",       {31'd0, s2_we_n},  32'd1);
    run2();
    check_eq("restart_low",   o_low, 32'd4);
    check_eq("restart_mem8",  {16'd0, mem2[8]}, 32'hF00D);
    check_eq("restart_mem9",  {16'd0, mem2[9]}, 32'hCAFE);
    check_eq("restart_rdata", rd_obs, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sram_controller
`default_nettype wire
